// File: rtl/seq_alu_if.sv
// Request/result bus of the sequential ALU: operands and opcode in, result and flags out.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [2:0]       opcode;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] w;
  logic             zero;
  logic             neg;
  logic             cout;

  modport master (
    output start, a, b, cin, opcode,
    input  busy, done, w, zero, neg, cout
  );

  modport slave (
    input  start, a, b, cin, opcode,
    output busy, done, w, zero, neg, cout
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: single-cycle ADD/SUB/logic/ASR, multi-cycle unsigned MUL (shift-add)
// and DIV (restoring). One operation in flight; result and flags held until next done.
module seq_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  seq_alu_if.slave bus
);

  localparam int unsigned SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t             state_q;
  logic [SHW-1:0]     cnt_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   opnd_q;   // multiplicand for MUL, divisor for DIV
  logic [2*WIDTH-1:0] prod_q;   // MUL product accumulator; low half is the DIV quotient
  logic [WIDTH-1:0]   rem_q;    // restored DIV remainder (always < divisor)
  logic               busy_q;
  logic               done_q;
  logic [WIDTH-1:0]   w_q;
  logic               zero_q;
  logic               neg_q;
  logic               cout_q;

  logic [WIDTH:0]     add_d;
  logic [WIDTH:0]     sub_d;
  logic [WIDTH-1:0]   res_d;
  logic               cout_d;
  logic [WIDTH:0]     mul_sum_d;
  logic [2*WIDTH-1:0] mul_next_d;
  logic [WIDTH:0]     div_sh_d;
  logic               div_ok_d;
  logic [WIDTH-1:0]   rem_next_d;
  logic [WIDTH-1:0]   quo_next_d;

  // Single-cycle result and status from the live request operands.
  always_comb begin
    add_d  = {1'b0, bus.a} + {1'b0, bus.b} + (WIDTH+1)'(bus.cin);
    sub_d  = {1'b0, bus.a} - {1'b0, bus.b} - (WIDTH+1)'(bus.cin);
    res_d  = '0;
    cout_d = 1'b0;
    case (bus.opcode)
      3'd0: begin
        res_d  = add_d[WIDTH-1:0];
        cout_d = add_d[WIDTH];
      end
      3'd1: begin
        // Negative W+1-bit difference means a < b + cin.
        res_d  = sub_d[WIDTH-1:0];
        cout_d = sub_d[WIDTH];
      end
      3'd2:    res_d = bus.a & bus.b;
      3'd3:    res_d = bus.a | bus.b;
      3'd4:    res_d = bus.a ^ bus.b;
      3'd5:    res_d = WIDTH'($signed(bus.a) >>> bus.b[SHW-1:0]);
      default: res_d = '0;
    endcase
  end

  // One shift-add step and one restoring-division step per RUN cycle.
  always_comb begin
    mul_sum_d  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
    mul_next_d = {mul_sum_d, prod_q[WIDTH-1:1]};
    div_sh_d   = {rem_q, prod_q[WIDTH-1]};
    div_ok_d   = (div_sh_d >= {1'b0, opnd_q});
    rem_next_d = div_ok_d ? WIDTH'(div_sh_d - {1'b0, opnd_q}) : div_sh_d[WIDTH-1:0];
    quo_next_d = {prod_q[WIDTH-2:0], div_ok_d};
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      prod_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      w_q      <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            if (bus.opcode[2:1] == 2'b11) begin
              is_div_q <= bus.opcode[0];
              opnd_q   <= bus.opcode[0] ? bus.b : bus.a;
              prod_q   <= {{WIDTH{1'b0}}, (bus.opcode[0] ? bus.a : bus.b)};
              rem_q    <= '0;
              cnt_q    <= SHW'(WIDTH - 1);
              busy_q   <= 1'b1;
              state_q  <= S_RUN;
            end else begin
              w_q    <= res_d;
              zero_q <= (res_d == '0);
              neg_q  <= res_d[WIDTH-1];
              cout_q <= cout_d;
              done_q <= 1'b1;
            end
          end
        end
        S_RUN: begin
          if (is_div_q) begin
            prod_q[WIDTH-1:0] <= quo_next_d;
            rem_q             <= rem_next_d;
          end else begin
            prod_q <= mul_next_d;
          end
          if (cnt_q == '0) begin
            state_q <= S_FIN;
          end else begin
            cnt_q <= cnt_q - SHW'(1);
          end
        end
        S_FIN: begin
          // A zero divisor leaves an all-ones quotient; flag it on cout.
          w_q     <= prod_q[WIDTH-1:0];
          zero_q  <= (prod_q[WIDTH-1:0] == '0);
          neg_q   <= prod_q[WIDTH-1];
          cout_q  <= is_div_q ? (opnd_q == '0) : (prod_q[2*WIDTH-1:WIDTH] != '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.w    = w_q;
  assign bus.zero = zero_q;
  assign bus.neg  = neg_q;
  assign bus.cout = cout_q;

endmodule
